// File: rtl/pif_xbus_ctl.sv
// pif_xbus_ctl
//   Bus front-end between the I2C slave core and the PIF register block.
//   It turns the received byte stream into XI-bus strobes and returns the
//   XO readback byte to the I2C slave after a fixed pipeline latency.
//
// Ports
//   xclk, xrst            clock (rising edge), async active-high reset
//   i2c_start, i2c_stop   bus condition pulses from the I2C slave
//   rx_valid, rx_byte     received byte: [TYPE_BITS-1:0] type, rest payload
//   tx_req, tx_done       read byte request / byte shifted out
//   tx_byte, tx_valid     read byte to transmit, held until tx_done
//   XI_PWr, XI_PRWA, XI_PD            write strobe, address, write data
//   XI_PRdSubA, XI_PRdFinished        read sub-address, read byte complete
//   XO                    readback byte from the register block
//
// State table
//   IDLE   | no transaction; waits for START
//   ACTIVE | transaction open; address/data bytes and read requests accepted
//   RWAIT  | read latency countdown before sampling XO
//   RREADY | read byte presented on tx_byte; waits for tx_done
module pif_xbus_ctl #(
  parameter int TYPE_BITS = 2,
  parameter int ADDR_W    = 8 - TYPE_BITS,
  parameter int SUBA_W    = 4,
  parameter int RD_LAT    = 5
) (
  input  logic                  xclk,
  input  logic                  xrst,
  input  logic                  i2c_start,
  input  logic                  i2c_stop,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_req,
  input  logic                  tx_done,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  output logic                  XI_PWr,
  output logic [ADDR_W-1:0]     XI_PRWA,
  output logic                  XI_PRdFinished,
  output logic [SUBA_W-1:0]     XI_PRdSubA,
  output logic [8-TYPE_BITS-1:0] XI_PD,
  input  logic [7:0]            XO
);

  localparam int PAY_W = 8 - TYPE_BITS;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACTIVE, RWAIT, RREADY} stateType;

  stateType             state, stateNext;
  logic [CNT_W-1:0]     latCnt, latCntNext;
  logic                 ldAddr, ldData, capRead, rdDone, abortRead;

  logic [PAY_W-1:0]     payload;
  logic [TYPE_BITS-1:0] byteType;

  assign payload  = rx_byte[7:TYPE_BITS];
  assign byteType = rx_byte[TYPE_BITS-1:0];

  always_ff @(posedge xclk or posedge xrst) begin
    if (xrst) begin
      state  <= IDLE;
      latCnt <= '0;
    end else begin
      state  <= stateNext;
      latCnt <= latCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    latCntNext = latCnt;
    ldAddr     = 1'b0;
    ldData     = 1'b0;
    capRead    = 1'b0;
    rdDone     = 1'b0;
    abortRead  = 1'b0;
    if (i2c_stop) begin
      stateNext  = IDLE;
      latCntNext = '0;
      abortRead  = 1'b1;
    end else if (i2c_start) begin
      stateNext  = ACTIVE;
      latCntNext = '0;
      abortRead  = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ACTIVE: begin
          if (rx_valid) begin
            ldAddr = (byteType == TYPE_BITS'(0));
            ldData = (byteType == TYPE_BITS'(1));
          end
          if (tx_req) begin
            stateNext  = RWAIT;
            latCntNext = CNT_W'(RD_LAT);
          end
        end
        RWAIT: begin
          // The capture edge is the one on which the counter reaches zero,
          // giving RD_LAT+1 cycles from tx_req to tx_valid.
          if (latCnt <= CNT_W'(1)) begin
            latCntNext = '0;
            capRead    = 1'b1;
            stateNext  = RREADY;
          end else begin
            latCntNext = latCnt - CNT_W'(1);
          end
        end
        RREADY: begin
          if (tx_done) begin
            rdDone    = 1'b1;
            stateNext = ACTIVE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge xclk or posedge xrst) begin
    if (xrst) begin
      tx_byte        <= '0;
      tx_valid       <= 1'b0;
      XI_PWr         <= 1'b0;
      XI_PRWA        <= '0;
      XI_PRdFinished <= 1'b0;
      XI_PRdSubA     <= '0;
      XI_PD          <= '0;
    end else begin
      XI_PWr         <= ldData;
      XI_PRdFinished <= rdDone;
      if (ldAddr) begin
        XI_PRWA    <= ADDR_W'(payload);
        XI_PRdSubA <= '0;
      end
      if (ldData) XI_PD <= payload;
      if (capRead) begin
        tx_byte  <= XO;
        tx_valid <= 1'b1;
      end
      if (abortRead || rdDone) tx_valid <= 1'b0;
      if (rdDone) XI_PRdSubA <= XI_PRdSubA + SUBA_W'(1);
    end
  end

endmodule
